// File: rtl/blink_rate_decoder.sv
// Measures toggle spacing on i_Blink, classifies it as 10/5/2/1 Hz, and flags lock/timeout.
// Optional: define BLINK_GLITCH_FILTER_EN to require 4 stable clocks before an edge counts.
module blink_rate_decoder #(
  parameter int unsigned g_COUNT_10HZ = 1250000,
  parameter int unsigned g_COUNT_5HZ  = 2500000,
  parameter int unsigned g_COUNT_2HZ  = 6250000,
  parameter int unsigned g_COUNT_1HZ  = 12500000,
  parameter int unsigned g_TOL_SHIFT  = 3,
  parameter int unsigned g_LOCK_COUNT = 4,
  localparam int unsigned TIMEOUT = 2 * g_COUNT_1HZ,
  localparam int unsigned W = $clog2(TIMEOUT + 1)
) (
  input  logic         i_Clk,
  input  logic         i_Reset,
  input  logic         i_Blink,
  output logic [2:0]   o_Rate,
  output logic         o_Valid,
  output logic         o_Locked,
  output logic         o_Timeout,
  output logic [W-1:0] o_Period
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MEAS = 2'd1;
  localparam logic [1:0] S_LOCK = 2'd2;
  localparam int unsigned RW = $clog2(g_LOCK_COUNT + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(g_LOCK_COUNT);

  logic         sync1_q, sync2_q, lvl_q;
  logic         edge_w, to_w;
  logic [W-1:0] cnt_q, cnt_d, meas_w;
  logic [2:0]   code_w;

  logic [1:0]    state_q, state_d;
  logic [RW-1:0] run_q, run_d;
  logic [2:0]    prev_q, prev_d, code_q, code_d;
  logic [W-1:0]  meas_q, meas_d;
  logic          v_q, v_d, to_q, to_d, lock_q, lock_d;

  logic [2:0]   rate_q;
  logic [W-1:0] period_q;
  logic         valid_q, tout_q, locked_q;

`ifdef BLINK_GLITCH_FILTER_EN
  logic       s3_q, chg_w;
  logic [1:0] stab_q, stab_d;

  assign chg_w  = sync2_q != s3_q;
  assign stab_d = chg_w ? 2'd0 : ((stab_q == 2'd3) ? 2'd3 : stab_q + 2'd1);
  assign edge_w = (sync2_q != lvl_q) && !chg_w && (stab_q == 2'd3);

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      s3_q   <= 1'b0;
      stab_q <= 2'd0;
    end else begin
      s3_q   <= sync2_q;
      stab_q <= stab_d;
    end
  end
`else
  assign edge_w = sync2_q != lvl_q;
`endif

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      lvl_q   <= 1'b0;
    end else begin
      sync1_q <= i_Blink;
      sync2_q <= sync1_q;
      if (edge_w) lvl_q <= sync2_q;
    end
  end

  // meas_w is the spacing this edge would report: count so far plus this clock
  assign meas_w = (cnt_q == W'(TIMEOUT)) ? cnt_q : cnt_q + W'(1);
  assign cnt_d  = edge_w ? '0 : meas_w;
  assign to_w   = !edge_w && (state_q != S_IDLE) && (cnt_q == W'(TIMEOUT - 1));

  function automatic logic in_band(input int unsigned m, input int unsigned c);
    return (m + (c >> g_TOL_SHIFT) >= c) && (m <= c + (c >> g_TOL_SHIFT));
  endfunction

  always_comb begin
    code_w = 3'd0;
    priority case (1'b1)
      in_band(32'(meas_w), g_COUNT_10HZ): code_w = 3'd1;
      in_band(32'(meas_w), g_COUNT_5HZ):  code_w = 3'd2;
      in_band(32'(meas_w), g_COUNT_2HZ):  code_w = 3'd3;
      in_band(32'(meas_w), g_COUNT_1HZ):  code_w = 3'd4;
      default: code_w = 3'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    prev_d  = prev_q;
    lock_d  = lock_q;
    code_d  = code_q;
    meas_d  = meas_q;
    v_d     = 1'b0;
    to_d    = 1'b0;
    if (edge_w) begin
      if (state_q == S_IDLE) begin
        state_d = S_MEAS;
      end else begin
        v_d    = 1'b1;
        code_d = code_w;
        meas_d = meas_w;
        prev_d = code_w;
        if (code_w == 3'd0) run_d = '0;
        else if (code_w != prev_q) run_d = RW'(1);
        else if (run_q != RUN_MAX) run_d = run_q + RW'(1);
        if (state_q == S_LOCK) begin
          if (code_w != prev_q) begin
            state_d = S_MEAS;
            lock_d  = 1'b0;
          end
        end else if (run_d == RUN_MAX) begin
          state_d = S_LOCK;
          lock_d  = 1'b1;
        end
      end
    end else if (to_w) begin
      state_d = S_IDLE;
      run_d   = '0;
      prev_d  = 3'd0;
      lock_d  = 1'b0;
      to_d    = 1'b1;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      cnt_q   <= '0;
      state_q <= S_IDLE;
      run_q   <= '0;
      prev_q  <= 3'd0;
      code_q  <= 3'd0;
      meas_q  <= '0;
      lock_q  <= 1'b0;
      v_q     <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      run_q   <= run_d;
      prev_q  <= prev_d;
      code_q  <= code_d;
      meas_q  <= meas_d;
      lock_q  <= lock_d;
      v_q     <= v_d;
      to_q    <= to_d;
    end
  end

  // Output stage: registered copy of the decision made one clock earlier
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      rate_q   <= 3'd0;
      period_q <= '0;
      valid_q  <= 1'b0;
      tout_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      valid_q  <= v_q;
      tout_q   <= to_q;
      locked_q <= lock_q;
      if (v_q) begin
        rate_q   <= code_q;
        period_q <= meas_q;
      end else if (to_q) begin
        rate_q <= 3'd0;
      end
    end
  end

  assign o_Rate    = rate_q;
  assign o_Period  = period_q;
  assign o_Valid   = valid_q;
  assign o_Timeout = tout_q;
  assign o_Locked  = locked_q;

endmodule

// File: tb/tb_blink_rate_decoder.sv
// Scoreboard bench for blink_rate_decoder with small counts (timeout = 100 clocks).
// Expectations are pushed when toggles are driven and popped on o_Valid/o_Timeout.
module tb_blink_rate_decoder;

  localparam int C10 = 5, C5 = 10, C2 = 25, C1 = 50;
  localparam int TSH = 2, LOCKN = 3, TMO = 2 * C1;
`ifdef BLINK_GLITCH_FILTER_EN
  localparam int LAT = 8;
`else
  localparam int LAT = 4;
`endif

  typedef struct {
    bit to;
    int cyc;
    int rate;
    int period;
    bit lock;
  } exp_t;

  logic       clk = 1'b0;
  logic       i_Reset, i_Blink;
  logic [2:0] o_Rate;
  logic       o_Valid, o_Locked, o_Timeout;
  logic [6:0] o_Period;

  int   cyc = 0;
  int   n_chk = 0, n_err = 0;
  exp_t sb[$];

  int t_last = 0, m_prev = 0, m_run = 0, m_period = 0;
  bit m_idle = 1'b1, m_lock = 1'b0;

  blink_rate_decoder #(
    .g_COUNT_10HZ(C10), .g_COUNT_5HZ(C5), .g_COUNT_2HZ(C2),
    .g_COUNT_1HZ(C1), .g_TOL_SHIFT(TSH), .g_LOCK_COUNT(LOCKN)
  ) dut (
    .i_Clk(clk), .i_Reset(i_Reset), .i_Blink(i_Blink),
    .o_Rate(o_Rate), .o_Valid(o_Valid), .o_Locked(o_Locked),
    .o_Timeout(o_Timeout), .o_Period(o_Period)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int cls(input int m);
    if (m >= C10 - (C10 >> TSH) && m <= C10 + (C10 >> TSH)) return 1;
    if (m >= C5 - (C5 >> TSH) && m <= C5 + (C5 >> TSH)) return 2;
    if (m >= C2 - (C2 >> TSH) && m <= C2 + (C2 >> TSH)) return 3;
    if (m >= C1 - (C1 >> TSH) && m <= C1 + (C1 >> TSH)) return 4;
    return 0;
  endfunction

  task automatic do_toggle();
    int s, c;
    exp_t e;
    i_Blink = ~i_Blink;
    if (m_idle) begin
      m_idle = 1'b0;
    end else begin
      s = cyc - t_last;
      c = cls(s);
      if (c == 0) m_run = 0;
      else if (c != m_prev) m_run = 1;
      else if (m_run < LOCKN) m_run++;
      if (m_lock) begin
        if (c != m_prev) m_lock = 1'b0;
      end else if (m_run == LOCKN) m_lock = 1'b1;
      m_prev = c;
      m_period = s;
      e = '{to: 1'b0, cyc: cyc + LAT, rate: c, period: s, lock: m_lock};
      sb.push_back(e);
    end
    t_last = cyc;
  endtask

  task automatic do_timeout();
    exp_t e;
    e = '{to: 1'b1, cyc: t_last + TMO + LAT, rate: 0, period: m_period, lock: 1'b0};
    sb.push_back(e);
    m_idle = 1'b1;
    m_prev = 0;
    m_run  = 0;
    m_lock = 1'b0;
  endtask

  task automatic gap(input int n, input bit tog);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (tog && k == n) do_toggle();
      else if (!m_idle && cyc - t_last == TMO) do_timeout();
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (o_Valid || o_Timeout) begin
      if (sb.size() == 0) begin
        check("unexpected_event", 32'(cyc), 32'(0));
      end else begin
        e = sb.pop_front();
        check("event_kind", 32'(o_Timeout), 32'(e.to));
        check("event_cycle", 32'(cyc), 32'(e.cyc));
        check("rate", 32'(o_Rate), 32'(e.rate));
        check("period", 32'(o_Period), 32'(e.period));
        check("locked", 32'(o_Locked), 32'(e.lock));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    i_Reset = 1'b1;
    i_Blink = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rate", 32'(o_Rate), 0);
    check("rst_valid", 32'(o_Valid), 0);
    check("rst_locked", 32'(o_Locked), 0);
    check("rst_timeout", 32'(o_Timeout), 0);
    check("rst_period", 32'(o_Period), 0);
    i_Reset = 1'b0;

    // 5 Hz: reference edge then five measurements of 10
    gap(3, 1);
    repeat (5) gap(10, 1);
    // switch to 1 Hz spacing
    repeat (4) gap(50, 1);
    // spacing 18 falls between bands
    repeat (3) gap(18, 1);
    // lock at 10 Hz, then stop toggling
    repeat (4) gap(5, 1);
    gap(250, 0);
    check("to_rate_hold", 32'(o_Rate), 0);
    check("to_locked_hold", 32'(o_Locked), 0);
    check("to_period_hold", 32'(o_Period), 32'(m_period));
    // edge lands exactly at the timeout count
    gap(3, 1);
    gap(TMO, 1);
    // lock at 10 Hz then reset mid-interval
    repeat (3) gap(5, 1);
    gap(6, 0);
    check("pre_rst_locked", 32'(o_Locked), 1);
    check("sb_drained", 32'(sb.size()), 0);
    #2;
    i_Reset = 1'b1;
    i_Blink = 1'b0;
    #1;
    check("async_rst_locked", 32'(o_Locked), 0);
    check("async_rst_rate", 32'(o_Rate), 0);
    check("async_rst_period", 32'(o_Period), 0);
    m_idle = 1'b1; m_prev = 0; m_run = 0; m_lock = 1'b0; m_period = 0;
    repeat (3) @(negedge clk);
    i_Reset = 1'b0;
    gap(4, 1);
    repeat (2) gap(5, 1);
    // 2-clock glitch
`ifdef BLINK_GLITCH_FILTER_EN
    repeat (20) @(negedge clk);
    i_Blink = ~i_Blink;
    repeat (2) @(negedge clk);
    i_Blink = ~i_Blink;
    gap(10, 0);
`else
    gap(20, 1);
    gap(2, 1);
`endif
    gap(150, 0);
    gap(20, 0);
    check("sb_empty_end", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
